// File: rtl/counting_element_gen_pkg.sv
// Shared constants and helpers for the counting element: lane encodings,
// lane decode and BCD digit validity.
package counter_pkg;

    localparam logic [1:0] RW_LSB  = 2'b01;
    localparam logic [1:0] RW_MSB  = 2'b10;
    localparam logic [1:0] RW_WORD = 2'b11;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        LaneWord,
        LaneLsb,
        LaneMsb
    } lane_e;

    // RW = 00 behaves as a full-width access.
    function automatic lane_e rw_to_lane(input logic [1:0] rw);
        lane_e lane;
        case (rw)
            RW_LSB:  lane = LaneLsb;
            RW_MSB:  lane = LaneMsb;
            default: lane = LaneWord;
        endcase
        return lane;
    endfunction

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/counting_element_gen_if.sv
// Mode, load, count and read-back signals of one counter channel.
// The mode/read logic is the master; the counting element is the slave.
interface counting_element_gen_if #(
    parameter int unsigned WIDTH = 16
);

    logic [WIDTH-1:0] initial_count;
    logic             load_new_count;
    logic             count_enable;
    logic             BCD;
    logic [1:0]       RW;
    logic             enableTwo;
    logic             auto_reload;
    logic             latch_cmd;
    logic             read_ack;

    logic [WIDTH-1:0] current_count;
    logic [WIDTH-1:0] latched_count;
    logic             latch_valid;
    logic             terminal_count;
    logic             zero_flag;
    logic             bcd_error;

    modport master (
        output initial_count, load_new_count, count_enable, BCD, RW, enableTwo,
        output auto_reload, latch_cmd, read_ack,
        input  current_count, latched_count, latch_valid, terminal_count,
        input  zero_flag, bcd_error
    );

    modport slave (
        input  initial_count, load_new_count, count_enable, BCD, RW, enableTwo,
        input  auto_reload, latch_cmd, read_ack,
        output current_count, latched_count, latch_valid, terminal_count,
        output zero_flag, bcd_error
    );

endinterface

// File: rtl/counting_element_gen_bcd_decrement.sv
// Combinational BCD subtract of 1 or 2 through a per-digit borrow chain,
// wrapping modulo 10^DIGITS. Digits above 9 simply decrement as 4-bit binary.
module bcd_decrement
    import counter_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic [DIGITS*DIGIT_W-1:0] value_i,
    input  logic                      two_i,
    output logic [DIGITS*DIGIT_W-1:0] value_o
);

    logic [DIGITS-1:0] borrow;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [DIGIT_W:0] sub;
        logic [DIGIT_W:0] diff;

        if (i == 0) begin : g_first
            assign sub = {{(DIGIT_W-1){1'b0}}, two_i, ~two_i};
        end else begin : g_chain
            assign sub = {{DIGIT_W{1'b0}}, borrow[i-1]};
        end

        assign diff      = {1'b0, value_i[i*DIGIT_W +: DIGIT_W]} - sub;
        assign borrow[i] = diff[DIGIT_W];
        // A negative digit result wraps to 10 + diff.
        assign value_o[i*DIGIT_W +: DIGIT_W] = diff[DIGIT_W]
                                             ? diff[DIGIT_W-1:0] + 4'd10
                                             : diff[DIGIT_W-1:0];
    end

    logic unused_borrow;
    assign unused_borrow = borrow[DIGITS-1];

endmodule

// File: rtl/counting_element_gen.sv
// One counter channel: lane-selectable binary/BCD down-counter with step 1/2,
// auto-reload, terminal-count pulse and a handshaked read-back latch.
module counting_element_gen
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic                 CLK,
    input logic                 RST_N,
    counting_element_gen_if.slave bus
);

    localparam int unsigned Digits     = WIDTH / DIGIT_W;
    localparam int unsigned ByteDigits = BYTE_W / DIGIT_W;

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] latched_q, latched_d;
    logic             latch_valid_q, latch_valid_d;
    logic             tc_q, tc_d;
    logic             bcd_err_q, bcd_err_d;

    lane_e            lane;
    logic [1:0]       step;
    logic [BYTE_W-1:0] lo_bcd, hi_bcd, lo_new, hi_new;
    logic [WIDTH-1:0] word_bcd, word_new;
    logic [WIDTH-1:0] count_dec, count_reload, load_value;
    logic             cur_zero, dec_zero, reload_take, load_bad;

    function automatic logic lane_zero(input logic [WIDTH-1:0] v, input lane_e l);
        logic z;
        case (l)
            LaneLsb: z = (v[7:0] == '0);
            LaneMsb: z = (v[15:8] == '0);
            default: z = (v == '0);
        endcase
        return z;
    endfunction

    assign lane = rw_to_lane(bus.RW);
    assign step = bus.enableTwo ? 2'd2 : 2'd1;

    bcd_decrement #(.DIGITS(ByteDigits)) u_bcd_lo (
        .value_i (count_q[7:0]),
        .two_i   (bus.enableTwo),
        .value_o (lo_bcd)
    );

    bcd_decrement #(.DIGITS(ByteDigits)) u_bcd_hi (
        .value_i (count_q[15:8]),
        .two_i   (bus.enableTwo),
        .value_o (hi_bcd)
    );

    bcd_decrement #(.DIGITS(Digits)) u_bcd_word (
        .value_i (count_q),
        .two_i   (bus.enableTwo),
        .value_o (word_bcd)
    );

    assign lo_new   = bus.BCD ? lo_bcd   : count_q[7:0]  - BYTE_W'(step);
    assign hi_new   = bus.BCD ? hi_bcd   : count_q[15:8] - BYTE_W'(step);
    assign word_new = bus.BCD ? word_bcd : count_q       - WIDTH'(step);

    // Odd values lose their LSB in step-2 mode so the count stays even.
    assign load_value = {bus.initial_count[WIDTH-1:1],
                         bus.initial_count[0] & ~bus.enableTwo};

    // Only the selected lane moves; the rest of the count is carried through.
    always_comb begin
        count_dec    = count_q;
        count_reload = count_q;
        case (lane)
            LaneLsb: begin
                count_dec[7:0]    = lo_new;
                count_reload[7:0] = {reload_q[7:1], reload_q[0] & ~bus.enableTwo};
            end
            LaneMsb: begin
                count_dec[15:8]    = hi_new;
                count_reload[15:8] = {reload_q[15:9], reload_q[8] & ~bus.enableTwo};
            end
            default: begin
                count_dec    = word_new;
                count_reload = {reload_q[WIDTH-1:1], reload_q[0] & ~bus.enableTwo};
            end
        endcase
    end

    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < int'(Digits); i++) begin
            load_bad |= digit_invalid(bus.initial_count[i*DIGIT_W +: DIGIT_W]);
        end
    end

    assign cur_zero    = lane_zero(count_q, lane);
    assign dec_zero    = lane_zero(count_dec, lane);
    assign reload_take = bus.auto_reload & cur_zero;

    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        tc_d      = 1'b0;
        bcd_err_d = bcd_err_q;
        if (bus.load_new_count) begin
            count_d   = load_value;
            reload_d  = bus.initial_count;
            bcd_err_d = bus.BCD & load_bad;
        end else if (bus.count_enable) begin
            count_d = reload_take ? count_reload : count_dec;
            tc_d    = ~reload_take & dec_zero;
        end
    end

    // Capture uses the pre-edge count; an acknowledge frees the latch and
    // masks a same-edge capture request.
    always_comb begin
        latched_d     = latched_q;
        latch_valid_d = latch_valid_q;
        if (latch_valid_q) begin
            if (bus.read_ack) begin
                latch_valid_d = 1'b0;
            end
        end else if (bus.latch_cmd) begin
            latched_d     = count_q;
            latch_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q       <= '0;
            reload_q      <= '0;
            latched_q     <= '0;
            latch_valid_q <= 1'b0;
            tc_q          <= 1'b0;
            bcd_err_q     <= 1'b0;
        end else begin
            count_q       <= count_d;
            reload_q      <= reload_d;
            latched_q     <= latched_d;
            latch_valid_q <= latch_valid_d;
            tc_q          <= tc_d;
            bcd_err_q     <= bcd_err_d;
        end
    end

    assign bus.current_count  = count_q;
    assign bus.latched_count  = latched_q;
    assign bus.latch_valid    = latch_valid_q;
    assign bus.terminal_count = tc_q;
    assign bus.zero_flag      = cur_zero;
    assign bus.bcd_error      = bcd_err_q;

endmodule

// File: doc/counting_element_gen.md
Name: counting_element_gen

Overview:
Parametrised successor to the 8254 counting element: a WIDTH-bit down-counter with true per-digit BCD arithmetic, step 1/2, byte-lane selection, optional auto-reload from a stored initial count, a terminal-count pulse and a read-back latch with handshake. Sits between the control-word/mode logic (which drives the mode inputs) and the output/read logic of one counter channel.

Parameters:
WIDTH, 16, counter width in bits; multiple of 8, >=16; BCD uses WIDTH/4 digits.

Ports:
CLK  in  1  counting clock; all state changes on rising edge
RST_N  in  1  asynchronous active-low reset
initial_count  in  WIDTH  count value loaded on load_new_count
load_new_count  in  1  load initial_count into counter and reload register
count_enable  in  1  decrement this cycle
BCD  in  1  1 = decimal arithmetic, 0 = binary
RW  in  2  lane select: 01 = bits[7:0], 10 = bits[15:8], 11 = full WIDTH (00 treated as 11)
enableTwo  in  1  decrement by 2 (square-wave mode)
auto_reload  in  1  reload from reload register instead of wrapping at zero
latch_cmd  in  1  capture current_count for read-back
read_ack  in  1  read-back consumed; frees latch
current_count  out  WIDTH  live count
latched_count  out  WIDTH  captured count
latch_valid  out  1  latched_count holds an unread capture
terminal_count  out  1  one-cycle pulse when selected lane reaches 0
zero_flag  out  1  combinational: selected lane of current_count == 0
bcd_error  out  1  last load contained a digit > 9 while BCD = 1

Behaviour:
- Reset (async, RST_N=0): current_count=0, reload register=0, latched_count=0, latch_valid=0, terminal_count=0, bcd_error=0; zero_flag=1 follows.
- Priority per edge: load_new_count > count_enable.
- Load: reload register <= initial_count; current_count <= initial_count, minus 1 if enableTwo && initial_count[0]; bcd_error <= BCD && any digit > 9. Load has one-cycle latency; no decrement that edge.
- Decrement (count_enable, no load): only the selected lane changes; other bits hold.
- Step s = enableTwo ? 2 : 1.
- Binary: lane <= lane - s modulo 2^lane_width.
- BCD: per-digit borrow chain, modulo 10^digits (0000 - 1 = 9999; 0001 - 2 = 9999; 0010 - 1 = 0009). Digits > 9 decrement as 4-bit binary within the chain; result unspecified, bcd_error flags it.
- Auto-reload: if auto_reload && lane == 0 on an enabled edge, lane <= corresponding lane of the reload register (odd-adjusted as on load) instead of wrapping.
- terminal_count <= 1 for exactly one cycle after an enabled edge whose result lane == 0; 0 otherwise. Reload-from-zero does not pulse.
- Latch: latch_cmd && !latch_valid -> latched_count <= current_count (pre-edge value, even with a simultaneous load or decrement), latch_valid <= 1.
- latch_cmd while latch_valid: ignored; latched value frozen.
- read_ack while latch_valid: latch_valid <= 0; a same-edge latch_cmd is ignored.
- read_ack while !latch_valid: no effect.
- Reset mid-operation clears everything immediately, including a pending latch.
- RW or BCD changing between edges takes effect on the next edge; no other state is disturbed.

Decomposition:
- Package counter_pkg: RW encodings (RW_LSB=2'b01, RW_MSB=2'b10, RW_WORD=2'b11), BYTE_W=8, digit-width constant 4.
- Sub-module bcd_decrement, parameter DIGITS: combinational per-digit borrow-chain subtract of 1 or 2. Instantiated for the 8-bit lanes and for full width; binary path is inline.

Test Plan:
- Reset then load 16'h0005 (binary, RW=11, step 1), enable 5 cycles -> 4,3,2,1,0; terminal_count pulses once after the 0 edge; zero_flag=1; next edge -> 16'hFFFF.
- BCD=1, load 16'h0010, enable 2 cycles -> 0009, 0008; load 0000, enable 1 -> 9999.
- enableTwo=1, load 16'h0007 -> 0006; enable 3 -> 0004, 0002, 0000; auto_reload=1, enable 1 -> 0006 with no terminal_count pulse.
- RW=01, load 16'h1203, enable 4 -> 1202, 1201, 1200, 12FF; upper byte constant throughout.
- latch_cmd at count 0x0040 while counting -> latched_count=0040, latch_valid=1; second latch_cmd ignored; read_ack -> latch_valid=0; latch_cmd with simultaneous load of 0x0100 -> latched_count=pre-load value.
- BCD=1, load 16'h00A5 -> bcd_error=1; load 16'h0095 -> bcd_error=0; assert RST_N=0 mid-count -> all outputs reset values asynchronously.
